// File: rtl/jtdd_adpcm_channel.sv
// ---------------------------------------------------------------------------
// jtdd_adpcm_channel
//
// One MSM5205-style ADPCM voice for the Double Dragon sound board. The sound
// CPU programs a start page and an end page, then issues START/STOP. While
// playing, the channel reads bytes from its own sample ROM, decodes the high
// nibble then the low nibble of each byte, and produces a 12-bit signed sample
// once every 48 pulses of the 375 kHz ADPCM enable (7.8125 kHz).
//
// Ports
//   clk       in   24 MHz system clock
//   rst       in   asynchronous, active-high reset
//   cpu_cen   in   sound-CPU clock enable, qualifies register writes
//   cen_oki   in   375 kHz single-cycle enable feeding the sample prescaler
//   cpu_dout  in   [7:0] CPU write data
//   cpu_AB    in   [1:0] register select: 0 START, 1 END, 2 STARTADDR, 3 STOP
//   cs        in   write strobe for this channel
//   rom_addr  out  [15:0] sample ROM byte address
//   rom_cs    out  high while playing; also the busy flag on the CPU status port
//   rom_data  in   [7:0] ROM byte for rom_addr
//   rom_ok    in   rom_data is valid for the current rom_addr
//   snd       out  [11:0] signed decoded sample
//
// Optional build macro
//   JTDD_ADPCM_DUMP_EN  when defined, a simulation-only trace prints every
//                       register write and every end-of-sample event. When
//                       undefined, no trace code is compiled at all.
// ---------------------------------------------------------------------------
module jtdd_adpcm_channel (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_cen,
    input  logic               cen_oki,
    input  logic [7:0]         cpu_dout,
    input  logic [1:0]         cpu_AB,
    input  logic               cs,
    output logic [15:0]        rom_addr,
    output logic               rom_cs,
    input  logic [7:0]         rom_data,
    input  logic               rom_ok,
    output logic signed [11:0] snd
);

    // Register-select codes for cpu_AB
    localparam logic [1:0] REG_START     = 2'd0;
    localparam logic [1:0] REG_END       = 2'd1;
    localparam logic [1:0] REG_STARTADDR = 2'd2;

    // Channel state
    logic [15:0]        pos;
    logic [6:0]         start_pg;
    logic [6:0]         end_pg;
    logic               hi_sel;
    logic [5:0]         idx;
    logic signed [11:0] signal;
    logic               playing;
    logic [5:0]         div_cnt;

    // Combinational decode results
    logic               wr;
    logic               tick;
    logic [3:0]         nibble;
    logic [10:0]        step;
    logic [11:0]        diff;
    logic signed [13:0] sig_wide;
    logic signed [13:0] sum;
    logic signed [11:0] signal_next;
    logic signed [7:0]  adj;
    logic signed [7:0]  idx_sum;
    logic [5:0]         idx_next;
    logic [15:0]        pos_inc;
    logic               end_hit;

    // Bit 7 of the page registers does not exist; the page is 7 bits wide.
    logic               unused_dout_msb;
    assign unused_dout_msb = cpu_dout[7];

    // MSM5205 step-size table, indexed by the adaptive step index (0..48).
    function automatic logic [10:0] step_lut(input logic [5:0] i);
        case (i)
            6'd0:  step_lut = 11'd16;
            6'd1:  step_lut = 11'd17;
            6'd2:  step_lut = 11'd19;
            6'd3:  step_lut = 11'd21;
            6'd4:  step_lut = 11'd23;
            6'd5:  step_lut = 11'd25;
            6'd6:  step_lut = 11'd28;
            6'd7:  step_lut = 11'd31;
            6'd8:  step_lut = 11'd34;
            6'd9:  step_lut = 11'd37;
            6'd10: step_lut = 11'd41;
            6'd11: step_lut = 11'd45;
            6'd12: step_lut = 11'd50;
            6'd13: step_lut = 11'd55;
            6'd14: step_lut = 11'd60;
            6'd15: step_lut = 11'd66;
            6'd16: step_lut = 11'd73;
            6'd17: step_lut = 11'd80;
            6'd18: step_lut = 11'd88;
            6'd19: step_lut = 11'd97;
            6'd20: step_lut = 11'd107;
            6'd21: step_lut = 11'd118;
            6'd22: step_lut = 11'd130;
            6'd23: step_lut = 11'd143;
            6'd24: step_lut = 11'd157;
            6'd25: step_lut = 11'd173;
            6'd26: step_lut = 11'd190;
            6'd27: step_lut = 11'd209;
            6'd28: step_lut = 11'd230;
            6'd29: step_lut = 11'd253;
            6'd30: step_lut = 11'd279;
            6'd31: step_lut = 11'd307;
            6'd32: step_lut = 11'd337;
            6'd33: step_lut = 11'd371;
            6'd34: step_lut = 11'd408;
            6'd35: step_lut = 11'd449;
            6'd36: step_lut = 11'd494;
            6'd37: step_lut = 11'd544;
            6'd38: step_lut = 11'd598;
            6'd39: step_lut = 11'd658;
            6'd40: step_lut = 11'd724;
            6'd41: step_lut = 11'd796;
            6'd42: step_lut = 11'd876;
            6'd43: step_lut = 11'd963;
            6'd44: step_lut = 11'd1060;
            6'd45: step_lut = 11'd1166;
            6'd46: step_lut = 11'd1282;
            6'd47: step_lut = 11'd1411;
            default: step_lut = 11'd1552;
        endcase
    endfunction

    assign wr       = cs & cpu_cen;
    assign tick     = cen_oki && (div_cnt == 6'd47);

    assign rom_addr = pos;
    assign rom_cs   = playing;
    assign snd      = signal;

    // Byte address after consuming the low nibble. Playback ends when this
    // lands exactly on the first byte of the end page, so a sample whose
    // start and end pages are equal runs the full 64 KB before it stops.
    assign pos_inc  = pos + 16'd1;
    assign end_hit  = (pos_inc[8:0] == 9'd0) && (pos_inc[15:9] == end_pg);

    // ADPCM decode of the current nibble. The sum is carried two bits wider
    // than the sample so the largest step added to a full-scale signal can
    // never wrap before it reaches the clamp.
    always_comb begin
        nibble = hi_sel ? rom_data[7:4] : rom_data[3:0];
        step   = step_lut(idx);

        diff = {4'd0, step[10:3]};
        if (nibble[2]) diff = diff + {1'b0, step};
        if (nibble[1]) diff = diff + {2'd0, step[10:1]};
        if (nibble[0]) diff = diff + {3'd0, step[10:2]};

        sig_wide = {{2{signal[11]}}, signal};
        sum      = nibble[3] ? (sig_wide - $signed({2'b00, diff}))
                             : (sig_wide + $signed({2'b00, diff}));

        if (sum > 14'sd2047)
            signal_next = 12'sd2047;
        else if (sum < -14'sd2048)
            signal_next = -12'sd2048;
        else
            signal_next = sum[11:0];

        case (nibble[2:0])
            3'd4:    adj = 8'sd2;
            3'd5:    adj = 8'sd4;
            3'd6:    adj = 8'sd6;
            3'd7:    adj = 8'sd8;
            default: adj = -8'sd1;
        endcase

        idx_sum = $signed({2'b00, idx}) + adj;
        if (idx_sum < 8'sd0)
            idx_next = 6'd0;
        else if (idx_sum > 8'sd48)
            idx_next = 6'd48;
        else
            idx_next = idx_sum[5:0];
    end

    // Sample prescaler: free-running count of cen_oki pulses, 0..47. It is
    // never touched by START so channel timing stays locked to the ADPCM clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div_cnt <= 6'd0;
        else if (cen_oki)
            div_cnt <= (div_cnt == 6'd47) ? 6'd0 : div_cnt + 6'd1;
    end

    // Register writes and sample ticks. A write always takes priority, and a
    // tick landing on the same edge is simply dropped. A tick with rom_ok low
    // is also dropped so the same nibble is decoded once the ROM catches up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos      <= 16'd0;
            start_pg <= 7'd0;
            end_pg   <= 7'd0;
            hi_sel   <= 1'b1;
            idx      <= 6'd0;
            signal   <= 12'sd0;
            playing  <= 1'b0;
        end else if (wr) begin
            case (cpu_AB)
                REG_START: begin
                    pos     <= {start_pg, 9'd0};
                    hi_sel  <= 1'b1;
                    idx     <= 6'd0;
                    signal  <= 12'sd0;
                    playing <= 1'b1;
                end
                REG_END:       end_pg   <= cpu_dout[6:0];
                REG_STARTADDR: start_pg <= cpu_dout[6:0];
                default: begin
                    playing <= 1'b0;
                    idx     <= 6'd0;
                    signal  <= 12'sd0;
                end
            endcase
        end else if (tick && playing && rom_ok) begin
            signal <= signal_next;
            idx    <= idx_next;
            if (hi_sel) begin
                hi_sel <= 1'b0;
            end else begin
                hi_sel <= 1'b1;
                pos    <= pos_inc;
                if (end_hit)
                    playing <= 1'b0;
            end
        end
    end

`ifdef JTDD_ADPCM_DUMP_EN
    // Simulation trace of CPU writes and of each sample reaching its end page.
    always @(posedge clk) begin
        if (!rst) begin
            if (wr)
                $display("jtdd_adpcm_channel: write reg %0d data %02x", cpu_AB, cpu_dout);
            else if (tick && playing && rom_ok && !hi_sel && end_hit)
                $display("jtdd_adpcm_channel: end of sample, pos %04x", pos_inc);
        end
    end
`else
    // Trace disabled: nothing extra is compiled.
`endif

endmodule

// File: tb/tb_jtdd_adpcm_channel.sv
// ---------------------------------------------------------------------------
// tb_jtdd_adpcm_channel
//
// Drives the ADPCM channel with directed sequences and randomized ROM data,
// enables and CPU writes. A reference model tracks the channel as a count of
// consumed nibbles from the start page plus the decoder's signal/step index,
// and every write or sample tick is compared against it.
// ---------------------------------------------------------------------------
module tb_jtdd_adpcm_channel;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_cen;
    logic               cen_oki;
    logic [7:0]         cpu_dout;
    logic [1:0]         cpu_AB;
    logic               cs;
    logic [15:0]        rom_addr;
    logic               rom_cs;
    logic [7:0]         rom_data;
    logic               rom_ok;
    logic signed [11:0] snd;

    jtdd_adpcm_channel dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_cen  (cpu_cen),
        .cen_oki  (cen_oki),
        .cpu_dout (cpu_dout),
        .cpu_AB   (cpu_AB),
        .cs       (cs),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .snd      (snd)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int stepTab[49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,
                        88,97,107,118,130,143,157,173,190,209,230,253,279,307,
                        337,371,408,449,494,544,598,658,724,796,876,963,1060,
                        1166,1282,1411,1552};
    int adjTab[8]   = '{-1,-1,-1,-1,2,4,6,8};
    int  mDiv, mSig, mIdx, mNib, mBase, mStart, mEnd;
    bit  mPlaying, mEvent;

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int modelPos();
        return (mBase * 512 + mNib / 2) % 65536;
    endfunction

    task automatic modelReset();
        mDiv = 0; mSig = 0; mIdx = 0; mNib = 0;
        mBase = 0; mStart = 0; mEnd = 0; mPlaying = 0;
    endtask

    // Decodes one nibble with plain integer arithmetic and advances playback.
    task automatic modelDecode(input int data);
        int n, step, diff;
        n    = (mNib % 2 == 0) ? (data / 16) : (data % 16);
        step = stepTab[mIdx];
        diff = step / 8;
        if (n & 4) diff += step;
        if (n & 2) diff += step / 2;
        if (n & 1) diff += step / 4;
        mSig = (n & 8) ? mSig - diff : mSig + diff;
        if (mSig > 2047)  mSig = 2047;
        if (mSig < -2048) mSig = -2048;
        mIdx += adjTab[n % 8];
        if (mIdx < 0)  mIdx = 0;
        if (mIdx > 48) mIdx = 48;
        mNib++;
        if (mNib % 2 == 0 && modelPos() % 512 == 0 && modelPos() / 512 == mEnd)
            mPlaying = 0;
    endtask

    // Applies the effect of one clock edge given the inputs held across it.
    task automatic modelStep();
        bit isWr, isTick;
        isWr   = cs && cpu_cen;
        isTick = 0;
        if (cen_oki) begin
            if (mDiv == 47) begin
                isTick = 1;
                mDiv   = 0;
            end else begin
                mDiv++;
            end
        end
        mEvent = isWr || isTick;
        if (isWr) begin
            case (cpu_AB)
                2'd0: begin mBase = mStart; mNib = 0; mSig = 0; mIdx = 0; mPlaying = 1; end
                2'd1: mEnd   = cpu_dout % 128;
                2'd2: mStart = cpu_dout % 128;
                default: begin mPlaying = 0; mSig = 0; mIdx = 0; end
            endcase
        end else if (isTick && mPlaying && rom_ok) begin
            modelDecode(rom_data);
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "_snd"},      snd,      mSig);
        checkOutput({tag, "_rom_addr"}, rom_addr, modelPos());
        checkOutput({tag, "_rom_cs"},   rom_cs,   mPlaying);
    endtask

    // One clock: inputs set before the edge, model stepped at the edge,
    // outputs sampled on the following falling edge.
    task automatic applyStimulus(input bit cen, input bit ok, input logic [7:0] data);
        cen_oki  = cen;
        rom_ok   = ok;
        rom_data = data;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        if (mEvent) compareAll("model");
    endtask

    task automatic cpuWrite(input logic [1:0] ab, input logic [7:0] data, input bit cen);
        cs       = 1'b1;
        cpu_cen  = 1'b1;
        cpu_AB   = ab;
        cpu_dout = data;
        applyStimulus(cen, rom_ok, rom_data);
        cs       = 1'b0;
    endtask

    task automatic runTicks(input int ticks, input bit ok, input logic [7:0] data);
        for (int i = 0; i < ticks * 48; i++)
            applyStimulus(1'b1, ok, data);
    endtask

    initial begin
        int   savedSig;
        bit   ended;

        rst = 1'b1; cpu_cen = 1'b1; cen_oki = 1'b0; cpu_dout = 8'd0;
        cpu_AB = 2'd0; cs = 1'b0; rom_data = 8'd0; rom_ok = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_rom_cs",   rom_cs,   0);
        checkOutput("reset_rom_addr", rom_addr, 0);
        checkOutput("reset_snd",      snd,      0);
        rst = 1'b0;

        // Start sequence from the datasheet example
        cpuWrite(2'd2, 8'h03, 1'b0);
        cpuWrite(2'd1, 8'h04, 1'b0);
        cpuWrite(2'd0, 8'h00, 1'b0);
        checkOutput("start_rom_cs",   rom_cs,   1);
        checkOutput("start_rom_addr", rom_addr, 16'h0600);

        // First decodes of 0x7F: high nibble 7, then low nibble F
        runTicks(1, 1'b1, 8'h7F);
        checkOutput("tick1_snd",      snd,      30);
        checkOutput("tick1_rom_addr", rom_addr, 16'h0600);
        runTicks(1, 1'b1, 8'h7F);
        checkOutput("tick2_snd",      snd,      -33);
        checkOutput("tick2_rom_addr", rom_addr, 16'h0601);

        // ROM stall: tick skipped, then the same (high) nibble resumes
        runTicks(1, 1'b0, 8'hA5);
        checkOutput("stall_snd",      snd,      -33);
        checkOutput("stall_rom_addr", rom_addr, 16'h0601);
        runTicks(1, 1'b1, 8'hA5);
        checkOutput("resume_snd",     snd,      -78);

        // Write coinciding with a tick: the tick is discarded
        for (int i = 0; i < 48 && mDiv != 47; i++)
            applyStimulus(1'b1, 1'b1, 8'h33);
        checkOutput("collide_align", mDiv, 47);
        savedSig = mSig;
        cpuWrite(2'd1, 8'h04, 1'b1);
        checkOutput("collide_snd",      snd,      savedSig);
        checkOutput("collide_rom_addr", rom_addr, 16'h0601);

        // STOP mid-play, then restart from a new start page
        cpuWrite(2'd2, 8'h05, 1'b0);
        cpuWrite(2'd1, 8'h10, 1'b0);
        cpuWrite(2'd0, 8'h00, 1'b0);
        runTicks(3, 1'b1, 8'h6C);
        cpuWrite(2'd3, 8'h00, 1'b0);
        checkOutput("stop_rom_cs", rom_cs, 0);
        checkOutput("stop_snd",    snd,    0);
        cpuWrite(2'd0, 8'h00, 1'b0);
        checkOutput("restart_rom_addr", rom_addr, 16'h0A00);
        checkOutput("restart_rom_cs",   rom_cs,   1);
        for (int i = 0; i < 48 && mDiv != 0; i++)
            applyStimulus(1'b1, 1'b1, 8'h7F);
        runTicks(1, 1'b1, 8'h7F);
        checkOutput("restart_snd", snd, 30);

        // Randomized playback with occasional random CPU writes
        for (int t = 0; t < 8000; t++) begin
            if ($urandom_range(0, 299) == 0 || (!mPlaying && $urandom_range(0, 39) == 0)) begin
                cs       = 1'b1;
                cpu_cen  = ($urandom_range(0, 3) != 0);
                cpu_AB   = mPlaying ? 2'($urandom) : 2'd0;
                cpu_dout = 8'($urandom);
            end
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 7) != 0, 8'($urandom));
            cs      = 1'b0;
            cpu_cen = 1'b1;
        end

        // End of sample: one page from 0x0600 stops on reaching 0x0800
        cpuWrite(2'd2, 8'h03, 1'b0);
        cpuWrite(2'd1, 8'h04, 1'b0);
        cpuWrite(2'd0, 8'h00, 1'b0);
        ended = 1'b0;
        for (int i = 0; i < 1030 * 48 && !ended; i++) begin
            applyStimulus(1'b1, 1'b1, 8'($urandom));
            if (!rom_cs) ended = 1'b1;
        end
        checkOutput("end_reached",  ended,    1);
        checkOutput("end_rom_addr", rom_addr, 16'h0800);
        repeat (100) applyStimulus(1'b1, 1'b1, 8'($urandom));
        checkOutput("end_snd_hold", snd,    mSig);
        checkOutput("end_rom_cs",   rom_cs, 0);

        // Reset asserted mid-playback forces reset values immediately
        cpuWrite(2'd0, 8'h00, 1'b0);
        runTicks(2, 1'b1, 8'h47);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_rom_cs",   rom_cs,   0);
        checkOutput("midreset_rom_addr", rom_addr, 0);
        checkOutput("midreset_snd",      snd,      0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        cpuWrite(2'd0, 8'h00, 1'b0);
        checkOutput("postreset_rom_addr", rom_addr, 16'h0000);
        runTicks(2, 1'b1, 8'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
